// File: rtl/ground_pkg.sv
// Shared definitions for the scrolling-horizon controller: game-state input
// encodings, controller FSM state type and the scroll-step width.
package ground_pkg;

    // gameState input encodings (2'b11 is reserved and behaves as GS_OVER)
    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_RUN  = 2'b01;
    localparam logic [1:0] GS_OVER = 2'b10;

    // Width of the scroll step (px/frame)
    localparam int unsigned DX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } gnd_state_t;

endpackage

// File: rtl/ground_speed_ramp.sv
// Scroll-speed ramp: counts RUN frames and raises the step by DX_STEP every
// RAMP_FRAMES frames, saturating at DX_MAX.
//   FrameClk : frame clock
//   rst      : asynchronous active-high reset
//   enable   : high on frames where the controller is in RUN
//   clear    : reload the initial speed and zero the frame counter
//   dx       : current scroll step, registered
module ground_speed_ramp
    import ground_pkg::*;
#(
    parameter int unsigned DX_INIT     = 6,
    parameter int unsigned DX_STEP     = 1,
    parameter int unsigned DX_MAX      = 20,
    parameter int unsigned RAMP_FRAMES = 600
) (
    input  logic            FrameClk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    output logic [DX_W-1:0] dx
);

    localparam int unsigned CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam int unsigned SUM_W = DX_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_FRAMES - 1);
    localparam logic [SUM_W-1:0] DX_MAX_W = SUM_W'(DX_MAX);
    localparam logic [DX_W-1:0]  DX_INIT_W = DX_W'(DX_INIT);
    localparam logic [DX_W-1:0]  DX_SAT_W  = DX_W'(DX_MAX);

    logic [CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [DX_W-1:0]  dx_q, dx_d;
    logic [SUM_W-1:0] dx_sum;

    // Next-state: clear wins over counting; the step is bumped on counter wrap
    always_comb begin
        ramp_cnt_d = ramp_cnt_q;
        dx_d       = dx_q;
        // one extra bit so the increment cannot wrap before the ceiling compare
        dx_sum     = {1'b0, dx_q} + SUM_W'(DX_STEP);

        if (clear) begin
            ramp_cnt_d = '0;
            dx_d       = DX_INIT_W;
        end else if (enable) begin
            if (ramp_cnt_q == CNT_LAST) begin
                ramp_cnt_d = '0;
                dx_d       = (dx_sum > DX_MAX_W) ? DX_SAT_W : dx_sum[DX_W-1:0];
            end else begin
                ramp_cnt_d = ramp_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            ramp_cnt_q <= '0;
            dx_q       <= DX_INIT_W;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
            dx_q       <= dx_d;
        end
    end

    assign dx = dx_q;

endmodule

// File: rtl/ground_scroll_controller.sv
// Frame-rate sequencer for the two-tile scrolling horizon. Tracks the game
// state, owns both ground tile X origins, ramps scroll speed and accumulates
// distance travelled. Every output is a flop.
//   FrameClk  : frame clock, one rising edge per displayed frame
//   rst       : asynchronous active-high reset
//   gameState : 00 idle, 01 running, 10 game over, 11 reserved (as 10)
//   Ground1X  : tile 1 X origin, signed
//   Ground2X  : tile 2 X origin, signed
//   scrollDx  : current scroll step (px/frame)
//   scrolling : high while in RUN
//   distance  : saturating sum of dx over all RUN frames
module ground_scroll_controller
    import ground_pkg::*;
#(
    parameter int unsigned TILE_W      = 600,
    parameter int unsigned DX_INIT     = 6,
    parameter int unsigned DX_STEP     = 1,
    parameter int unsigned DX_MAX      = 20,
    parameter int unsigned RAMP_FRAMES = 600
) (
    input  logic            FrameClk,
    input  logic            rst,
    input  logic [1:0]      gameState,
    output logic [31:0]     Ground1X,
    output logic [31:0]     Ground2X,
    output logic [DX_W-1:0] scrollDx,
    output logic            scrolling,
    output logic [31:0]     distance
);

    localparam logic signed [31:0] TILE_W_S   = 32'(TILE_W);
    localparam logic signed [31:0] TILE_W_NEG = -TILE_W_S;
    localparam logic [31:0]        DIST_SAT   = 32'hFFFF_FFFF;

    gnd_state_t state_q, state_d;
    logic       reinit;
    logic       run;

    logic signed [31:0] ground1_q, ground1_d;
    logic signed [31:0] ground2_q, ground2_d;
    logic [31:0]        dist_q, dist_d;
    logic               scrolling_q, scrolling_d;

    logic [DX_W-1:0]    dx;
    logic signed [31:0] dx_ext;
    logic signed [31:0] n1, n2;
    logic [32:0]        dist_sum;

    // Movement applies only on edges where the registered state is RUN
    assign run = (state_q == ST_RUN);

    // FSM next-state; leaving RUN/HALT for IDLE, or HALT for RUN, reinitialises
    always_comb begin
        state_d = state_q;
        reinit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gameState == GS_RUN) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case (gameState)
                    GS_RUN:  state_d = ST_RUN;
                    GS_IDLE: begin
                        state_d = ST_IDLE;
                        reinit  = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_HALT: begin
                case (gameState)
                    GS_IDLE: begin
                        state_d = ST_IDLE;
                        reinit  = 1'b1;
                    end
                    GS_RUN: begin
                        state_d = ST_RUN;
                        reinit  = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
                reinit  = 1'b1;
            end
        endcase
    end

    // Tile movement, wrap and distance accumulation
    always_comb begin
        ground1_d   = ground1_q;
        ground2_d   = ground2_q;
        dist_d      = dist_q;
        scrolling_d = (state_d == ST_RUN);

        dx_ext   = {{(32 - DX_W){1'b0}}, dx};
        n1       = ground1_q - dx_ext;
        n2       = ground2_q - dx_ext;
        dist_sum = {1'b0, dist_q} + {1'b0, 32'(dx)};

        if (reinit) begin
            ground1_d = '0;
            ground2_d = TILE_W_S;
            dist_d    = '0;
        end else if (run) begin
            // a tile that has fully left the screen re-enters one tile behind its partner
            ground1_d = (n1 <= TILE_W_NEG) ? (n2 + TILE_W_S) : n1;
            ground2_d = (n2 <= TILE_W_NEG) ? (n1 + TILE_W_S) : n2;
            dist_d    = dist_sum[32] ? DIST_SAT : dist_sum[31:0];
        end
    end

    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ground1_q   <= '0;
            ground2_q   <= TILE_W_S;
            dist_q      <= '0;
            scrolling_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ground1_q   <= ground1_d;
            ground2_q   <= ground2_d;
            dist_q      <= dist_d;
            scrolling_q <= scrolling_d;
        end
    end

    // The ramp advances on the same edges that move the tiles
    ground_speed_ramp #(
        .DX_INIT     (DX_INIT),
        .DX_STEP     (DX_STEP),
        .DX_MAX      (DX_MAX),
        .RAMP_FRAMES (RAMP_FRAMES)
    ) u_speed_ramp (
        .FrameClk (FrameClk),
        .rst      (rst),
        .enable   (run),
        .clear    (reinit),
        .dx       (dx)
    );

    assign Ground1X  = ground1_q;
    assign Ground2X  = ground2_q;
    assign scrollDx  = dx;
    assign scrolling = scrolling_q;
    assign distance  = dist_q;

endmodule
